signal_patch_ctrl: RTL and testbench

Runtime configuration controller for the patch fabric's signal-control points, i.e. the `control signal` taps. It accepts a byte-serial configuration frame over a valid/ready port and validates it with a header, a slot count and an XOR checksum. A frame that passes is committed atomically to a bank of per-slot override registers, and those registers drive a forced value onto each controlled signal. It sits between the SoC patch programming port and the patched design's control-point muxes.

---
 rtl/signal_patch_ctrl_if.sv | 19 +
 rtl/signal_patch_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_signal_patch_ctrl.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/signal_patch_ctrl_if.sv
// Byte-serial configuration port: 8-bit data with valid/ready handshake.
// A byte transfers on any rising edge where cfg_valid && cfg_ready.
interface signal_patch_ctrl_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (
    output cfg_data,
    output cfg_valid,
    input  cfg_ready
  );

  modport slave (
    input  cfg_data,
    input  cfg_valid,
    output cfg_ready
  );
endinterface

// File: rtl/signal_patch_ctrl.sv
// Validates byte-serial override frames and commits them atomically to per-slot
// override registers; latency: commit visible one cycle after the checksum byte; ready drops only in RESOLVE.
module signal_patch_ctrl #(
  parameter int          NUM_SLOTS = 8,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  signal_patch_ctrl_if.slave   cfg,
  input  logic                 clear_all,
  input  logic [NUM_SLOTS-1:0] sig_in,
  output logic [NUM_SLOTS-1:0] sig_out,
  output logic [NUM_SLOTS-1:0] ctrl_en,
  output logic [NUM_SLOTS-1:0] ctrl_val,
  output logic                 cfg_done,
  output logic                 cfg_err,
  output logic                 err_sticky
);

  localparam logic [8:0] NS = 9'(NUM_SLOTS);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_IDX, S_VAL, S_CSUM, S_RESOLVE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [7:0]           idx_q, idx_d;
  logic [7:0]           xor_q, xor_d;
  logic                 bad_q, bad_d;
  logic                 csum_ok_q, csum_ok_d;
  logic [NUM_SLOTS-1:0] sh_en_q, sh_en_d;
  logic [NUM_SLOTS-1:0] sh_val_q, sh_val_d;
  logic [NUM_SLOTS-1:0] act_en_q, act_en_d;
  logic [NUM_SLOTS-1:0] act_val_q, act_val_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 sticky_q, sticky_d;
  logic                 hs;
  logic [7:0]           dat;

  assign cfg.cfg_ready = rst_n && (state_q != S_RESOLVE);
  assign hs            = cfg.cfg_valid && cfg.cfg_ready;
  assign dat           = cfg.cfg_data;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    bad_d     = bad_q;
    csum_ok_d = csum_ok_q;
    sh_en_d   = sh_en_q;
    sh_val_d  = sh_val_q;
    act_en_d  = act_en_q;
    act_val_d = act_val_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Shadow starts as a copy of active so unnamed slots keep their value.
        if (hs && dat == SYNC) begin
          state_d   = S_COUNT;
          sh_en_d   = act_en_q;
          sh_val_d  = act_val_q;
          xor_d     = SYNC;
          bad_d     = 1'b0;
          csum_ok_d = 1'b0;
        end
      end
      S_COUNT: begin
        if (hs) begin
          xor_d = xor_q ^ dat;
          if (dat == 8'd0 || {1'b0, dat} > NS) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = dat;
            state_d = S_IDX;
          end
        end
      end
      S_IDX: begin
        if (hs) begin
          xor_d = xor_q ^ dat;
          idx_d = dat;
          if ({1'b0, dat} >= NS) begin
            bad_d = 1'b1;
          end
          state_d = S_VAL;
        end
      end
      S_VAL: begin
        if (hs) begin
          xor_d = xor_q ^ dat;
          // An out-of-range index matches no slot, so nothing is written.
          for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx_q == 8'(i)) begin
              sh_en_d[i]  = dat[1];
              sh_val_d[i] = dat[0];
            end
          end
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? S_CSUM : S_IDX;
        end
      end
      S_CSUM: begin
        if (hs) begin
          csum_ok_d = (dat == xor_q);
          state_d   = S_RESOLVE;
        end
      end
      S_RESOLVE: begin
        if (csum_ok_q && !bad_q) begin
          act_en_d  = sh_en_q;
          act_val_d = sh_val_q;
          done_d    = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    sticky_d = sticky_q | err_d;

    if (clear_all) begin
      state_d   = S_IDLE;
      cnt_d     = 8'd0;
      idx_d     = 8'd0;
      xor_d     = 8'd0;
      bad_d     = 1'b0;
      csum_ok_d = 1'b0;
      sh_en_d   = '0;
      sh_val_d  = '0;
      act_en_d  = '0;
      act_val_d = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      sticky_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      idx_q     <= 8'd0;
      xor_q     <= 8'd0;
      bad_q     <= 1'b0;
      csum_ok_q <= 1'b0;
      sh_en_q   <= '0;
      sh_val_q  <= '0;
      act_en_q  <= '0;
      act_val_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      bad_q     <= bad_d;
      csum_ok_q <= csum_ok_d;
      sh_en_q   <= sh_en_d;
      sh_val_q  <= sh_val_d;
      act_en_q  <= act_en_d;
      act_val_q <= act_val_d;
      done_q    <= done_d;
      err_q     <= err_d;
      sticky_q  <= sticky_d;
    end
  end

  assign ctrl_en    = act_en_q;
  assign ctrl_val   = act_val_q;
  assign sig_out    = (act_en_q & act_val_q) | (~act_en_q & sig_in);
  assign cfg_done   = done_q;
  assign cfg_err    = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_signal_patch_ctrl.sv
// Bench for signal_patch_ctrl: directed frame table, hand sequences for
// count errors / clear_all / back-to-back, then random frames against a frame-level model.
module tb_signal_patch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_all = 1'b0;
  logic [7:0] sig_in = 8'h00;
  logic [7:0] sig_out, ctrl_en, ctrl_val;
  logic       cfg_done, cfg_err, err_sticky;

  signal_patch_ctrl_if bif();

  signal_patch_ctrl #(.NUM_SLOTS(8), .SYNC(8'hA5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg        (bif.slave),
    .clear_all  (clear_all),
    .sig_in     (sig_in),
    .sig_out    (sig_out),
    .ctrl_en    (ctrl_en),
    .ctrl_val   (ctrl_val),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      done_cnt <= done_cnt + int'(cfg_done);
      err_cnt  <= err_cnt + int'(cfg_err);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0][7:0] b;
    int               len;
    bit               ok;
    logic [7:0]       en;
    logic [7:0]       val;
    bit               st;
  } vec_t;

  vec_t tbl[6];
  logic [7:0] fq[$];

  task automatic set_vec(input int i, input logic [127:0] b, input int len, input bit ok,
                         input logic [7:0] en, input logic [7:0] val, input bit st);
    tbl[i].b   = b;
    tbl[i].len = len;
    tbl[i].ok  = ok;
    tbl[i].en  = en;
    tbl[i].val = val;
    tbl[i].st  = st;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int guard;
    if (gap) begin
      bif.cfg_valid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge clk);
      #1;
    end
    bif.cfg_data  = b;
    bif.cfg_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!bif.cfg_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 20) chk("handshake_timeout", 32'(guard), 32'd0);
    @(posedge clk);
    #1;
    bif.cfg_valid = 1'b0;
  endtask

  task automatic send_fq(input bit gaps);
    foreach (fq[k]) send_byte(fq[k], gaps && ($urandom_range(0, 3) == 0));
  endtask

  // Entered just after the checksum handshake edge E.
  task automatic frame_end(input string tag, input bit ok, input logic [7:0] e_en,
                           input logic [7:0] e_val, input bit e_st);
    sig_in = 8'($urandom);
    @(negedge clk);
    chk({tag, "_resolve_ready"}, 32'(bif.cfg_ready), 32'd0);
    chk({tag, "_early_pulse"}, 32'({cfg_done, cfg_err}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_done"}, 32'(cfg_done), 32'(ok));
    chk({tag, "_err"}, 32'(cfg_err), 32'(!ok));
    chk({tag, "_en"}, 32'(ctrl_en), 32'(e_en));
    chk({tag, "_val"}, 32'(ctrl_val), 32'(e_val));
    chk({tag, "_sticky"}, 32'(err_sticky), 32'(e_st));
    chk({tag, "_sig_out"}, 32'(sig_out), 32'((e_en & e_val) | (~e_en & sig_in)));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] m_en, m_val, te, tv, x, idx, mode, cs;
    bit         m_st, bad, ok;
    int         n, d0, e0, low, guard;

    set_vec(0, 128'({8'hA5, 8'h01, 8'h03, 8'h03, 8'hA4}), 5, 1'b1, 8'h08, 8'h08, 1'b0);
    set_vec(1, 128'({8'hA5, 8'h01, 8'h03, 8'h03, 8'hA5}), 5, 1'b0, 8'h08, 8'h08, 1'b1);
    set_vec(2, 128'({8'hA5, 8'h02, 8'h09, 8'h03, 8'h05, 8'h02, 8'hAA}), 7, 1'b0, 8'h08, 8'h08, 1'b1);
    set_vec(3, 128'({8'hA5, 8'h02, 8'h01, 8'h02, 8'h01, 8'h03, 8'hA6}), 7, 1'b1, 8'h0A, 8'h0A, 1'b1);
    set_vec(4, 128'({8'hA5, 8'h02, 8'h03, 8'h00, 8'h00, 8'h01, 8'hA5}), 7, 1'b1, 8'h02, 8'h03, 1'b1);
    set_vec(5, 128'({8'hA5, 8'h01, 8'h07, 8'hFE, 8'h5D}), 5, 1'b1, 8'h82, 8'h03, 1'b1);

    bif.cfg_data  = 8'h00;
    bif.cfg_valid = 1'b0;

    // Reset behaviour
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(bif.cfg_ready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sig_in = 8'h5C;
    @(negedge clk);
    chk("post_reset_ready", 32'(bif.cfg_ready), 32'd1);
    chk("post_reset_en", 32'(ctrl_en), 32'd0);
    chk("post_reset_val", 32'(ctrl_val), 32'd0);
    chk("post_reset_flags", 32'({cfg_done, cfg_err, err_sticky}), 32'd0);
    chk("post_reset_sig_out", 32'(sig_out), 32'h5C);
    @(posedge clk);
    #1;

    // Directed frame table
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < tbl[i].len; k++) send_byte(tbl[i].b[tbl[i].len - 1 - k], 1'b0);
      frame_end($sformatf("tbl%0d", i), tbl[i].ok, tbl[i].en, tbl[i].val, tbl[i].st);
    end

    // Count errors: 00 and 09, followed by orphan entry bytes
    for (int c = 0; c < 2; c++) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(8'hA5, 1'b0);
      send_byte((c == 0) ? 8'h00 : 8'h09, 1'b0);
      @(negedge clk);
      chk($sformatf("cnterr%0d_err", c), 32'(cfg_err), 32'd1);
      chk($sformatf("cnterr%0d_ready", c), 32'(bif.cfg_ready), 32'd1);
      @(posedge clk);
      #1;
      fq = '{8'h01, 8'h03, 8'h03, 8'hA4};
      send_fq(1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("cnterr%0d_pulses", c), 32'(err_cnt - e0), 32'd1);
      chk($sformatf("cnterr%0d_nodone", c), 32'(done_cnt - d0), 32'd0);
      chk($sformatf("cnterr%0d_en", c), 32'(ctrl_en), 32'h82);
    end

    // clear_all after second entry byte of a valid frame
    d0 = done_cnt;
    e0 = err_cnt;
    fq = '{8'hA5, 8'h02, 8'h01, 8'h03};
    send_fq(1'b0);
    bif.cfg_data  = 8'h02;
    bif.cfg_valid = 1'b1;
    clear_all     = 1'b1;
    @(posedge clk);
    #1;
    clear_all     = 1'b0;
    bif.cfg_valid = 1'b0;
    sig_in = 8'hC3;
    @(negedge clk);
    chk("clr_en", 32'(ctrl_en), 32'd0);
    chk("clr_val", 32'(ctrl_val), 32'd0);
    chk("clr_sticky", 32'(err_sticky), 32'd0);
    chk("clr_ready", 32'(bif.cfg_ready), 32'd1);
    chk("clr_sig_out", 32'(sig_out), 32'hC3);
    repeat (3) @(posedge clk);
    #1;
    chk("clr_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    fq = '{8'hA5, 8'h01, 8'h03, 8'h03, 8'hA4};
    send_fq(1'b0);
    frame_end("clr_next", 1'b1, 8'h08, 8'h08, 1'b0);

    // Back-to-back frames with valid held high
    d0 = done_cnt;
    fq = '{8'hA5, 8'h01, 8'h03, 8'h03, 8'hA4, 8'hA5, 8'h02, 8'h01, 8'h02, 8'h01, 8'h03, 8'hA6};
    low = 0;
    bif.cfg_valid = 1'b1;
    foreach (fq[k]) begin
      bif.cfg_data = fq[k];
      guard = 0;
      @(negedge clk);
      while (!bif.cfg_ready && guard < 20) begin
        low++;
        guard++;
        @(negedge clk);
      end
      @(posedge clk);
      #1;
    end
    bif.cfg_valid = 1'b0;
    chk("b2b_ready_low_cycles", 32'(low), 32'd1);
    frame_end("b2b", 1'b1, 8'h0A, 8'h0A, 1'b0);
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);

    // Random frames against the frame-level model
    m_en  = 8'h0A;
    m_val = 8'h0A;
    m_st  = 1'b0;
    for (int f = 0; f < 40; f++) begin
      n   = $urandom_range(1, 8);
      fq  = '{8'hA5, 8'(n)};
      x   = 8'hA5 ^ 8'(n);
      bad = 1'b0;
      te  = m_en;
      tv  = m_val;
      for (int j = 0; j < n; j++) begin
        idx  = ($urandom_range(0, 9) == 9) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
        mode = 8'($urandom);
        fq.push_back(idx);
        fq.push_back(mode);
        x = x ^ idx ^ mode;
        if (idx >= 8) bad = 1'b1;
        else begin
          te[idx[2:0]] = mode[1];
          tv[idx[2:0]] = mode[0];
        end
      end
      cs = ($urandom_range(0, 4) == 0) ? (x ^ 8'($urandom_range(1, 255))) : x;
      fq.push_back(cs);
      ok = !bad && (cs == x);
      if (ok) begin
        m_en  = te;
        m_val = tv;
      end else begin
        m_st = 1'b1;
      end
      send_fq(1'b1);
      frame_end($sformatf("rnd%0d", f), ok, m_en, m_val, m_st);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
